// File: rtl/sort_stream_out_pkg.sv
// Shared sort constants and element-indexing helpers, so every stage of the
// sort pipeline slices a frame into elements the same way.
package sort_stream_out_pkg;

  localparam int SORT_N = 8;
  localparam int SORT_K = 8;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Element i occupies bits [(i+1)*K-1 : i*K] of a frame.
  function automatic int elem_lsb(input int idx, input int k);
    return idx * k;
  endfunction

endpackage

// File: rtl/sort_stream_out_elem_mux.sv
// Selects one K-bit element out of an N*K frame vector.
module sort_elem_mux
  import sort_stream_out_pkg::*;
#(
  parameter int N  = SORT_N,
  parameter int K  = SORT_K,
  parameter int IW = idx_w(N)
) (
  input  logic [N*K-1:0] i_vec,
  input  logic [IW-1:0]  i_idx,
  output logic [K-1:0]   o_elem
);

  always_comb begin
    o_elem = '0;
    for (int i = 0; i < N; i++) begin
      if (i_idx == IW'(i)) o_elem = i_vec[elem_lsb(i, K) +: K];
    end
  end

endmodule

// File: rtl/sort_stream_out.sv
// Sort pipeline output stage: active + pending frame slots, each frame
// streamed one element per cycle on valid/ready with last-element marking.
module sort_stream_out
  import sort_stream_out_pkg::*;
#(
  parameter int N       = SORT_N,
  parameter int K       = SORT_K,
  parameter int DESCEND = 0
) (
  input  logic           i_clk,
  input  logic           i_rstn,
  input  logic [N*K-1:0] i_in_data,
  input  logic           i_in_valid,
  output logic           o_in_ready,
  output logic [K-1:0]   o_out_data,
  output logic           o_out_valid,
  input  logic           i_out_ready,
  output logic           o_out_last,
  output logic           o_busy
);

  localparam int            IW   = idx_w(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  logic [N*K-1:0] r_act_data, r_pend_data;
  logic           r_act_vld, r_pend_vld;
  logic [IW-1:0]  r_act_idx;

  logic           w_in_fire, w_out_fire, w_act_done, w_act_free;
  logic [IW-1:0]  w_sel;
  logic [K-1:0]   w_elem;

  // in_ready depends on registered state only, never on out_ready.
  assign o_in_ready  = ~r_pend_vld;
  assign o_out_valid = r_act_vld;
  assign o_out_last  = r_act_vld & (r_act_idx == LAST);
  assign o_busy      = r_act_vld | r_pend_vld;

  assign w_in_fire  = i_in_valid & o_in_ready;
  assign w_out_fire = o_out_valid & i_out_ready;
  assign w_act_done = w_out_fire & o_out_last;
  assign w_act_free = ~r_act_vld | w_act_done;

  assign w_sel = (DESCEND != 0) ? (LAST - r_act_idx) : r_act_idx;

  sort_elem_mux #(.N(N), .K(K), .IW(IW)) u_mux (
    .i_vec  (r_act_data),
    .i_idx  (w_sel),
    .o_elem (w_elem)
  );

  assign o_out_data = r_act_vld ? w_elem : '0;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_act_data  <= '0;
      r_pend_data <= '0;
      r_act_vld   <= 1'b0;
      r_pend_vld  <= 1'b0;
      r_act_idx   <= '0;
    end else if (w_act_free) begin
      // Pending frame has priority; in_ready is low then, so no in_fire.
      if (r_pend_vld) begin
        r_act_data <= r_pend_data;
        r_act_idx  <= '0;
        r_act_vld  <= 1'b1;
        r_pend_vld <= 1'b0;
      end else if (w_in_fire) begin
        r_act_data <= i_in_data;
        r_act_idx  <= '0;
        r_act_vld  <= 1'b1;
      end else begin
        r_act_vld  <= 1'b0;
      end
    end else begin
      if (w_out_fire) r_act_idx <= r_act_idx + 1'b1;
      if (w_in_fire) begin
        r_pend_data <= i_in_data;
        r_pend_vld  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sort_stream_out.sv
// Scoreboard bench for sort_stream_out: ascending and descending instances
// share one stimulus stream and are checked against a frame-level model.
module tb_sort_stream_out;

  localparam int N = 4;
  localparam int K = 8;

  logic          clk = 0;
  logic          rstn;
  logic [N*K-1:0] in_data;
  logic          in_valid, out_ready;
  logic          in_ready0, out_valid0, out_last0, busy0;
  logic          in_ready1, out_valid1, out_last1, busy1;
  logic [K-1:0]  out_data0, out_data1;

  always #5 clk = ~clk;

  sort_stream_out #(.N(N), .K(K), .DESCEND(0)) d0 (
    .i_clk(clk), .i_rstn(rstn), .i_in_data(in_data), .i_in_valid(in_valid),
    .o_in_ready(in_ready0), .o_out_data(out_data0), .o_out_valid(out_valid0),
    .i_out_ready(out_ready), .o_out_last(out_last0), .o_busy(busy0));

  sort_stream_out #(.N(N), .K(K), .DESCEND(1)) d1 (
    .i_clk(clk), .i_rstn(rstn), .i_in_data(in_data), .i_in_valid(in_valid),
    .o_in_ready(in_ready1), .o_out_data(out_data1), .o_out_valid(out_valid1),
    .i_out_ready(out_ready), .o_out_last(out_last1), .o_busy(busy1));

  typedef struct packed { logic [K-1:0] d; logic l; } exp_t;

  exp_t q0[$], q1[$];
  int   held  = 0;   // frames accepted but not yet fully emitted
  int   fires = 0;
  int   total = 0, passed = 0;
  int   orm   = 0;   // out_ready pattern: 0 always, 1 toggle 1,0,0,1, 2 random

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    else passed++;
  endtask

  // Monitor: check outputs against the model, then apply the coming edge.
  always @(negedge clk) begin
    int  h;
    logic infire;
    h = held;
    chk("in_ready0", 32'(in_ready0), 32'(h < 2));
    chk("in_ready1", 32'(in_ready1), 32'(h < 2));
    chk("busy0", 32'(busy0), 32'(h > 0));
    chk("busy1", 32'(busy1), 32'(h > 0));
    chk("out_valid0", 32'(out_valid0), 32'(h > 0));
    chk("out_valid1", 32'(out_valid1), 32'(h > 0));
    if (h > 0) begin
      chk("out_data0", 32'(out_data0), 32'(q0[0].d));
      chk("out_last0", 32'(out_last0), 32'(q0[0].l));
      chk("out_data1", 32'(out_data1), 32'(q1[0].d));
      chk("out_last1", 32'(out_last1), 32'(q1[0].l));
    end else begin
      chk("idle_data0", 32'(out_data0), 0);
      chk("idle_last0", 32'(out_last0), 0);
      chk("idle_data1", 32'(out_data1), 0);
      chk("idle_last1", 32'(out_last1), 0);
    end
    if (!rstn) begin
      q0.delete(); q1.delete(); held = 0;
    end else begin
      infire = in_valid && (h < 2);
      if (h > 0 && out_ready) begin
        fires++;
        if (q0[0].l) held--;
        void'(q0.pop_front());
        void'(q1.pop_front());
      end
      if (infire) begin
        for (int e = 0; e < N; e++) begin
          q0.push_back('{d: in_data[e*K +: K], l: (e == N-1)});
          q1.push_back('{d: in_data[(N-1-e)*K +: K], l: (e == N-1)});
        end
        held++;
      end
    end
  end

  int orc = 0;
  always @(posedge clk) begin
    #1;
    orc++;
    case (orm)
      0: out_ready = 1'b1;
      1: out_ready = (orc % 4 == 0) || (orc % 4 == 3);
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic offer(input logic [N*K-1:0] f);
    int  n = 0;
    logic acc;
    in_data  = f;
    in_valid = 1'b1;
    do begin
      @(negedge clk); acc = in_ready0;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) chk("offer_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (held > 0 && n < 500) begin @(negedge clk); n++; end
    if (held > 0) chk("drain_timeout", 32'(held), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    rstn = 1'b0; in_valid = 1'b1; in_data = 32'hdeadbeef; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1; in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    orm = 0;
    offer(32'h40302010);
    drain();

    offer(32'h04030201);
    offer(32'h08070605);
    drain();

    orm = 1;
    offer(32'h14131211);
    offer(32'h18171615);
    offer(32'h1c1b1a19);
    drain();

    // Reset with one frame mid-stream and another pending.
    orm = 0;
    begin
      int base, n;
      base = fires; n = 0;
      offer(32'h24232221);
      offer(32'h28272625);
      while (fires < base + 2 && n < 50) begin @(negedge clk); n++; end
      @(posedge clk); #1 rstn = 1'b0;
      @(posedge clk); #1 rstn = 1'b1;
      repeat (6) @(posedge clk);
      #1;
    end

    orm = 2;
    for (int f = 0; f < 40; f++) begin
      offer({8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)});
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    drain();
    orm = 0;
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sort_stream_out.md
Name: sort_stream_out

Overview:
- Output stage placed directly after the final odd/even compare-exchange phase of the sort pipeline.
- Accepts one sorted N*K frame per handshake and streams its N elements out one per cycle on a valid/ready interface, with last-element marking.
- Two frame slots (active + pending) let the next frame be accepted while the current one drains, so back-to-back frames stream with no gap cycles.

Parameters:
- N, 8, elements per frame; even, >= 2.
- K, 8, element width in bits.
- DESCEND, 0, 0: emit element 0 (bits K-1:0, smallest) first; 1: emit element N-1 (largest) first.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rstn  input  1  reset, synchronous, active-low.
- in_data  input  N*K  sorted frame; element i at bits [(i+1)*K-1 : i*K].
- in_valid  input  1  in_data holds a frame.
- in_ready  output  1  block can accept a frame this cycle.
- out_data  output  K  current element.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_last  output  1  current element is the final element of its frame.
- busy  output  1  active or pending slot occupied.

Behaviour:
- Reset: the block has one clock and a synchronous, active-low reset. While rstn=0 at a rising edge:
  - act_vld, pend_vld and act_idx clear to 0.
  - Data registers clear to 0.
  - Resulting outputs: out_valid=0, out_last=0, out_data=0, in_ready=1, busy=0.
- Reset mid-frame discards both slots. No partial frame is emitted after rstn rises.
- State: active slot (act_data N*K, act_vld, act_idx of clog2(N) bits) and pending slot (pend_data N*K, pend_vld).
- Derived signals:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - act_done = out_fire & out_last.
  - act_free = ~act_vld | act_done.
- Output signals:
  - in_ready = ~pend_vld. It is a registered-state function only, with no combinational path from out_ready.
  - out_valid = act_vld.
  - out_last = act_vld & (act_idx == N-1).
  - busy = act_vld | pend_vld.
- out_data is selected by DESCEND:
  - DESCEND=0: element act_idx of act_data.
  - DESCEND=1: element N-1-act_idx of act_data.
  - out_data is 0 when act_vld=0.
- Element stepping: on out_fire with out_last=0, act_idx increments by 1.
- Slot update, evaluated in priority order each cycle:
  1. act_free & pend_vld: pend→active, act_idx=0, act_vld=1, pend_vld=0. in_fire cannot occur because in_ready=0.
  2. act_free & ~pend_vld & in_fire: in_data→active directly, act_idx=0, act_vld=1.
  3. act_free & ~pend_vld & ~in_fire: act_vld=0.
  4. ~act_free & in_fire: in_data→pending, pend_vld=1.
- Latency: frame accepted into an idle block produces out_valid=1 on the next cycle with element 0 (DESCEND=0).
- Throughput: with out_ready held 1 and frames offered continuously, one element per cycle, gapless across frame boundaries.
- Back-pressure:
  - out_ready=0 holds out_data, out_last and act_idx stable.
  - With both slots full, in_ready=0 until the active frame's last element fires.
- Once out_valid=1, it stays 1 and out_data stays stable until out_fire.
- Frames are never reordered and never dropped.
- Simultaneous last-element out_fire and in_fire with pending empty: the new frame loads directly to active, with no bubble.

Decomposition:
- Shared sort package holds:
  - Default N/K constants.
  - Index-width function clog2(N).
  - Element-slice helper, so the sort stages and this block index elements identically.
- One natural sub-module: sort_elem_mux (N*K vector + index → K-bit element), reused by later debug/readback blocks.
- Slot control stays inline.

Test Plan:
- Reset: N=4, K=8, rstn=0 for 2 cycles with in_valid=1 → out_valid=0, out_data=0, busy=0, in_ready=1. After release, nothing is emitted until a frame is accepted.
- Single frame, DESCEND=0: in_data={8'h40,8'h30,8'h20,8'h10}, out_ready=1 → out_valid rises the cycle after accept, then:
  - out_data sequence 10,20,30,40 on consecutive cycles.
  - out_last=1 only on 40.
  - out_valid=0 on the following cycle.
- DESCEND=1 on the same frame → sequence 40,30,20,10; out_last on 10.
- Back-to-back frames: frames A={04,03,02,01} and B={08,07,06,05} offered continuously, out_ready=1 → 8 consecutive valid cycles 01..08, out_last on 04 and 08. in_ready drops to 0 only while the pending slot is full.
- Back-pressure: out_ready toggled 1,0,0,1,… during a frame → each element appears exactly once and is held stable while out_ready=0. A third frame offered while A is active and B is pending sees in_ready=0 until A's last element fires.
- Reset mid-stream: assert rstn=0 after 2 of 4 elements with a frame pending → next cycle out_valid=0, busy=0. The remaining elements and the pending frame are never emitted.
